// File: rtl/vector_unpacker.sv
// Width down-converter: accepts one IN_W-bit word per handshake and replays it as
// IN_W/OUT_W consecutive OUT_W-bit slices on a valid/ready stream.
module vector_unpacker #(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int unsigned RATIO = IN_W / OUT_W;
  localparam int unsigned IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  if ((IN_W % OUT_W) != 0 || RATIO < 2) begin : g_param_check
    $error("vector_unpacker: IN_W must be a multiple of OUT_W with at least two slices");
  end

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           state_q;
  logic [IN_W-1:0]  hold_q;
  logic [IDX_W-1:0] idx_q;
  logic [OUT_W-1:0] slices [RATIO];
  logic             in_xfer;
  logic             out_xfer;

  // Slice k is the k-th one emitted, so the order is fixed here rather than in idx.
  for (genvar k = 0; k < RATIO; k++) begin : g_slice
    if (MSB_FIRST) begin : g_msb
      assign slices[k] = hold_q[IN_W-1-k*OUT_W -: OUT_W];
    end else begin : g_lsb
      assign slices[k] = hold_q[k*OUT_W +: OUT_W];
    end
  end

  assign out_valid = (state_q == StFull);
  assign busy      = out_valid;
  assign out_last  = (state_q == StFull) && (idx_q == IDX_W'(RATIO - 1));
  assign out_data  = slices[idx_q];
  assign in_ready  = !rst && ((state_q == StEmpty) || (out_ready && out_last));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            hold_q  <= in_data;
            idx_q   <= '0;
            state_q <= StFull;
          end
        end
        StFull: begin
          if (out_xfer) begin
            if (!out_last) begin
              idx_q <= idx_q + 1'b1;
            end else if (in_xfer) begin
              // Reload on the final slice so back-to-back words stream without a bubble.
              hold_q <= in_data;
              idx_q  <= '0;
            end else begin
              idx_q   <= '0;
              state_q <= StEmpty;
            end
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_unpacker.sv
// Scoreboard bench for vector_unpacker: three instances (8/4 MSB-first, 8/4 LSB-first,
// 16/4 MSB-first) with directed cases followed by randomized traffic.
module tb_vector_unpacker;

  logic clk;
  logic rst;

  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a, busy_a;
  logic [7:0]  in_data_a;
  logic [3:0]  out_data_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b, busy_b;
  logic [7:0]  in_data_b;
  logic [3:0]  out_data_b;
  logic        in_valid_c, in_ready_c, out_valid_c, out_ready_c, out_last_c, busy_c;
  logic [15:0] in_data_c;
  logic [3:0]  out_data_c;

  int checks   = 0;
  int failures = 0;

  logic [4:0] q_a[$];
  logic [4:0] q_b[$];
  logic [4:0] q_c[$];

  vector_unpacker #(.IN_W(8), .OUT_W(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .out_last(out_last_a), .busy(busy_a)
  );

  vector_unpacker #(.IN_W(8), .OUT_W(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .busy(busy_b)
  );

  vector_unpacker #(.IN_W(16), .OUT_W(4), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid_c), .in_ready(in_ready_c), .in_data(in_data_c),
    .out_valid(out_valid_c), .out_ready(out_ready_c), .out_data(out_data_c),
    .out_last(out_last_c), .busy(busy_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slice k of a word, numbered in emission order, by shift-and-mask arithmetic.
  function automatic logic [3:0] model_slice(input logic [15:0] w, input int in_w,
                                             input bit msb, input int k);
    int sh;
    sh = msb ? (in_w - 4 * (k + 1)) : (4 * k);
    return 4'(w >> sh);
  endfunction

  // Monitors: sample at negedge, push expected slices on input transfer, pop on output.
  initial begin
    logic       stall;
    logic [4:0] prev;
    logic [4:0] e;
    stall = 0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("a_in_ready_rst", in_ready_a, 0);
        q_a.delete();
        stall = 0;
      end else begin
        chk("a_busy", busy_a, out_valid_a);
        chk("a_in_ready", in_ready_a, !out_valid_a || (out_ready_a && out_last_a));
        if (stall) begin
          chk("a_hold_valid", out_valid_a, 1);
          chk("a_hold_data", {out_last_a, out_data_a}, prev);
        end
        if (out_valid_a && out_ready_a) begin
          chk("a_pop_nonempty", q_a.size() != 0, 1);
          if (q_a.size() != 0) begin
            e = q_a.pop_front();
            chk("a_data", out_data_a, e[3:0]);
            chk("a_last", out_last_a, e[4]);
          end
        end
        if (in_valid_a && in_ready_a)
          for (int k = 0; k < 2; k++)
            q_a.push_back({(k == 1), model_slice({8'h0, in_data_a}, 8, 1'b1, k)});
        stall = out_valid_a && !out_ready_a;
        prev  = {out_last_a, out_data_a};
      end
    end
  end

  initial begin
    logic       stall;
    logic [4:0] prev;
    logic [4:0] e;
    stall = 0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("b_in_ready_rst", in_ready_b, 0);
        q_b.delete();
        stall = 0;
      end else begin
        chk("b_busy", busy_b, out_valid_b);
        chk("b_in_ready", in_ready_b, !out_valid_b || (out_ready_b && out_last_b));
        if (stall) begin
          chk("b_hold_valid", out_valid_b, 1);
          chk("b_hold_data", {out_last_b, out_data_b}, prev);
        end
        if (out_valid_b && out_ready_b) begin
          chk("b_pop_nonempty", q_b.size() != 0, 1);
          if (q_b.size() != 0) begin
            e = q_b.pop_front();
            chk("b_data", out_data_b, e[3:0]);
            chk("b_last", out_last_b, e[4]);
          end
        end
        if (in_valid_b && in_ready_b)
          for (int k = 0; k < 2; k++)
            q_b.push_back({(k == 1), model_slice({8'h0, in_data_b}, 8, 1'b0, k)});
        stall = out_valid_b && !out_ready_b;
        prev  = {out_last_b, out_data_b};
      end
    end
  end

  initial begin
    logic       stall;
    logic [4:0] prev;
    logic [4:0] e;
    stall = 0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("c_in_ready_rst", in_ready_c, 0);
        q_c.delete();
        stall = 0;
      end else begin
        chk("c_busy", busy_c, out_valid_c);
        chk("c_in_ready", in_ready_c, !out_valid_c || (out_ready_c && out_last_c));
        if (stall) begin
          chk("c_hold_valid", out_valid_c, 1);
          chk("c_hold_data", {out_last_c, out_data_c}, prev);
        end
        if (out_valid_c && out_ready_c) begin
          chk("c_pop_nonempty", q_c.size() != 0, 1);
          if (q_c.size() != 0) begin
            e = q_c.pop_front();
            chk("c_data", out_data_c, e[3:0]);
            chk("c_last", out_last_c, e[4]);
          end
        end
        if (in_valid_c && in_ready_c)
          for (int k = 0; k < 4; k++)
            q_c.push_back({(k == 3), model_slice(in_data_c, 16, 1'b1, k)});
        stall = out_valid_c && !out_ready_c;
        prev  = {out_last_c, out_data_c};
      end
    end
  end

  // Offer a word to instance a until accepted; returns just after the accepting edge.
  task automatic send_a(input logic [7:0] w);
    int n;
    n = 0;
    in_valid_a = 1'b1;
    in_data_a  = w;
    @(negedge clk);
    while (!in_ready_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("a_send_accepted", in_ready_a, 1);
    @(posedge clk);
    #1;
    in_valid_a = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    logic [3:0] exp3 [4];
    logic [3:0] exp6 [4];
    int n;
    exp3 = '{4'hA, 4'h5, 4'h3, 4'hC};
    exp6 = '{4'h1, 4'h2, 4'h3, 4'h4};
    clk = 0;
    rst = 1;
    in_valid_a = 0; in_data_a = '0; out_ready_a = 0;
    in_valid_b = 0; in_data_b = '0; out_ready_b = 0;
    in_valid_c = 0; in_data_c = '0; out_ready_c = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid_a, 0);
    chk("rst_in_ready", in_ready_a, 0);
    chk("rst_out_data", out_data_a, 0);
    chk("rst_out_last", out_last_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_out_valid_c", out_valid_c, 0);
    @(posedge clk);
    #1;
    rst = 0;
    out_ready_a = 1; out_ready_b = 1; out_ready_c = 1;

    // MSB-first and LSB-first unpacking of the same byte.
    in_valid_a = 1; in_data_a = 8'hA5;
    in_valid_b = 1; in_data_b = 8'hA5;
    @(negedge clk);
    chk("t1_in_ready_empty", in_ready_a, 1);
    @(posedge clk);
    #1;
    in_valid_a = 0; in_valid_b = 0;
    @(negedge clk);
    chk("t1_valid_n1", out_valid_a, 1);
    chk("t1_data_n1", out_data_a, 4'hA);
    chk("t1_last_n1", out_last_a, 0);
    chk("t2_data_n1", out_data_b, 4'h5);
    chk("t2_last_n1", out_last_b, 0);
    @(negedge clk);
    chk("t1_data_n2", out_data_a, 4'h5);
    chk("t1_last_n2", out_last_a, 1);
    chk("t2_data_n2", out_data_b, 4'hA);
    chk("t2_last_n2", out_last_b, 1);
    @(negedge clk);
    chk("t1_valid_n3", out_valid_a, 0);
    chk("t2_valid_n3", out_valid_b, 0);

    // Back-to-back words must stream with no gap.
    @(posedge clk);
    #1;
    fork
      begin
        send_a(8'hA5);
        send_a(8'h3C);
      end
      begin
        n = 0;
        @(negedge clk);
        while (!out_valid_a && n < 20) begin
          @(negedge clk);
          n++;
        end
        for (int k = 0; k < 4; k++) begin
          chk("t3_valid", out_valid_a, 1);
          chk("t3_data", out_data_a, exp3[k]);
          chk("t3_in_ready_on_last", in_ready_a, out_last_a);
          if (k < 3) @(negedge clk);
        end
      end
    join

    // Backpressure holds the first slice and blocks input.
    @(posedge clk);
    #1;
    out_ready_a = 0;
    send_a(8'hA5);
    repeat (3) begin
      @(negedge clk);
      chk("t4_valid", out_valid_a, 1);
      chk("t4_data_held", out_data_a, 4'hA);
      chk("t4_in_ready", in_ready_a, 0);
    end
    @(posedge clk);
    #1;
    out_ready_a = 1;
    @(negedge clk);
    chk("t4_resume_first", out_data_a, 4'hA);
    @(negedge clk);
    chk("t4_resume_second", out_data_a, 4'h5);
    chk("t4_resume_last", out_last_a, 1);
    @(negedge clk);
    chk("t4_empty", out_valid_a, 0);

    // Reset mid-word discards the rest of the held word.
    @(posedge clk);
    #1;
    send_a(8'hA5);
    @(negedge clk);
    chk("t5_first", out_data_a, 4'hA);
    @(posedge clk);
    #1;
    rst = 1;
    @(negedge clk);
    chk("t5_in_ready_rst", in_ready_a, 0);
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("t5_valid_after_rst", out_valid_a, 0);
    @(posedge clk);
    #1;
    send_a(8'h3C);
    @(negedge clk);
    chk("t5_data0", out_data_a, 4'h3);
    chk("t5_last0", out_last_a, 0);
    @(negedge clk);
    chk("t5_data1", out_data_a, 4'hC);
    chk("t5_last1", out_last_a, 1);

    // 16-bit word into four nibbles.
    @(posedge clk);
    #1;
    in_valid_c = 1; in_data_c = 16'h1234;
    @(negedge clk);
    chk("t6_in_ready", in_ready_c, 1);
    @(posedge clk);
    #1;
    in_valid_c = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t6_valid", out_valid_c, 1);
      chk("t6_data", out_data_c, exp6[k]);
      chk("t6_last", out_last_c, (k == 3) ? 1 : 0);
    end
    @(negedge clk);
    chk("t6_empty", out_valid_c, 0);

    // Randomized traffic on all instances, checked by the monitors.
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      in_valid_a = ($urandom_range(0, 3) != 0);
      in_data_a = 8'($urandom);
      out_ready_a = ($urandom_range(0, 2) != 0);
      in_valid_b = ($urandom_range(0, 3) != 0);
      in_data_b = 8'($urandom);
      out_ready_b = ($urandom_range(0, 2) != 0);
      in_valid_c = ($urandom_range(0, 3) != 0);
      in_data_c = 16'($urandom);
      out_ready_c = ($urandom_range(0, 1) != 0);
    end
    @(posedge clk);
    #1;
    in_valid_a = 0; in_valid_b = 0; in_valid_c = 0;
    out_ready_a = 1; out_ready_b = 1; out_ready_c = 1;
    n = 0;
    @(negedge clk);
    while ((out_valid_a || out_valid_b || out_valid_c) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_idle", out_valid_a || out_valid_b || out_valid_c, 0);
    chk("drain_q_a", q_a.size(), 0);
    chk("drain_q_b", q_b.size(), 0);
    chk("drain_q_c", q_c.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_unpacker.md
Name: vector_unpacker

Overview:
- Width down-converter. Accepts one IN_W-bit word per handshake and emits it as IN_W/OUT_W consecutive OUT_W-bit slices on a valid/ready stream.
- Performs the inverse of the team's nibble-concatenation packing: a byte built as {hi, lo} comes back out as hi, then lo.
- Sits between wide datapath registers and narrow consumers such as nibble-wide display, serial or debug paths.

Parameters:
- IN_W, 8, input word width; must be an integer multiple of OUT_W.
- OUT_W, 4, output slice width.
- MSB_FIRST, 1, 1 = emit the most-significant slice first; 0 = emit the least-significant slice first.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  in_data is valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  IN_W  word to unpack
- out_valid  output  1  out_data holds a valid slice
- out_ready  input  1  consumer accepts the slice this cycle
- out_data  output  OUT_W  current slice
- out_last  output  1  current slice is the final slice of its word
- busy  output  1  a word is held (equal to out_valid)

Behaviour:
- Elaboration:
  - RATIO = IN_W/OUT_W.
  - Elaboration fails ($error or equivalent) if IN_W % OUT_W != 0 or RATIO < 2.
- Storage and counting:
  - hold register: IN_W bits.
  - slice index idx: clog2(RATIO) bits.
- States:
  - EMPTY: no word held.
  - FULL: a word is held and slice idx is presented.
- Reset (rst=1 at a clock edge), all synchronous:
  - state=EMPTY, idx=0, hold=0.
  - out_valid=0, out_data=0, out_last=0, busy=0.
  - in_ready=0 in every cycle where rst=1.
- Handshakes:
  - in_ready = !rst && (state==EMPTY || (out_ready && out_last)). Combinational; depends on out_ready.
  - Input transfer = in_valid && in_ready at a clock edge.
  - Output transfer = out_valid && out_ready at a clock edge.
- EMPTY, on input transfer: capture in_data into hold, set idx=0, go to FULL.
- Latency: a word accepted at edge N presents its first slice from cycle N+1 (registered, no combinational in-to-out path).
- Slice mapping, for slice k (0-based):
  - MSB_FIRST=1: hold[IN_W-1-k*OUT_W -: OUT_W].
  - MSB_FIRST=0: hold[k*OUT_W +: OUT_W].
  - out_data is driven from hold and idx.
- out_last = (state==FULL && idx==RATIO-1).
- FULL, on output transfer with out_last=0: idx increments; state stays FULL.
- FULL, on output transfer with out_last=1:
  - With a simultaneous input transfer: load the new word, idx=0, stay FULL. No bubble.
  - Otherwise: go to EMPTY, idx=0.
- Backpressure (out_valid=1, out_ready=0):
  - out_data, out_last, idx and hold are stable.
  - in_ready=0 while state==FULL.
- Throughput: sustained one slice per cycle. Back-to-back words give RATIO*W consecutive valid slices with no gaps.
- in_data is ignored when in_ready=0. No word is dropped or duplicated.
- Reset mid-word: the held word is discarded. The first slice after reset comes from the next accepted word, starting at slice 0.
- out_valid stays asserted until its slice is accepted. It is never withdrawn except by rst.

Test Plan:
1. Default params, rst then in_data=8'hA5 with out_ready=1 held:
   - out_data=4'hA (out_last=0) in cycle N+1.
   - out_data=4'h5 (out_last=1) in cycle N+2.
   - out_valid=0 in cycle N+3.
2. MSB_FIRST=0, in_data=8'hA5: out_data sequence is 4'h5, then 4'hA with out_last=1.
3. Back-to-back 8'hA5, 8'h3C, in_valid and out_ready held high:
   - slices A,5,3,C in 4 consecutive cycles.
   - in_ready high exactly on the cycles out_last=1 (or when EMPTY).
4. Backpressure: in_data=8'hA5, out_ready=0 for 3 cycles:
   - out_data holds 4'hA, in_ready=0.
   - out_ready=1 resumes with 4'h5; no slice is lost or repeated.
5. Reset mid-word: after 4'hA is emitted, rst=1 for 1 cycle:
   - out_valid=0 and in_ready=0 during reset.
   - next word 8'h3C yields 4'h3, then 4'hC; no 4'h5 ever appears.
6. IN_W=16, OUT_W=4, in_data=16'h1234:
   - slices 1,2,3,4 in order.
   - out_last asserted only with 4'h4.
   - Randomized out_ready: output stream matches a reference model.
